// File: rtl/fwd_hazard_if.sv
// ID-stage hazard/forwarding bundle: the instruction in ID plus the stall,
// forward-select and stall-counter results returned by the hazard unit.
interface fwd_hazard_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
);
  logic                       id_valid;
  logic [NUM_SRC*REG_AW-1:0]  id_rs;
  logic [NUM_SRC-1:0]         id_rs_used;
  logic [REG_AW-1:0]          id_rd;
  logic                       id_reg_write;
  logic                       id_mem_read;
  logic                       flush;
  logic                       stall;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic [CNT_W-1:0]           stall_count;

  // Pipeline control side: presents the ID instruction, consumes the results.
  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_mem_read, flush,
    input  stall, fwd_sel, stall_count
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_mem_read, flush,
    output stall, fwd_sel, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit. A shadow pipeline mirrors the producers
// in EX and later stages; forward selects are resolved in ID and registered so
// they arrive in EX together with the consuming instruction.
module fwd_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1),
  parameter int CNT_W     = 16
) (
  input logic         clk,
  input logic         rst,
  fwd_hazard_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } shadow_t;

  // shadow[0] = EX, shadow[1] = MEM, ... shadow[FWD_DEPTH].
  shadow_t                   shadow [FWD_DEPTH+1];
  shadow_t                   id_entry;
  logic [NUM_SRC-1:0]        hazard;
  logic                      stall_c;
  logic                      take;
  logic [NUM_SRC*SEL_W-1:0]  sel_d;
  logic [NUM_SRC*SEL_W-1:0]  sel_q;
  logic [CNT_W-1:0]          cnt_q;

  function automatic logic is_producer(shadow_t e);
    return e.valid && e.reg_write && (e.rd != '0);
  endfunction

  assign id_entry = '{valid:     1'b1,
                      rd:        bus.id_rd,
                      reg_write: bus.id_reg_write,
                      mem_read:  bus.id_mem_read};

  // Load-use detection: a read operand whose producer is a load still inside
  // the not-yet-ready window. Flush suppresses it entirely.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    hazard = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < LOAD_LAT; k++) begin
        if (bus.id_valid && bus.id_rs_used[i] && !bus.flush &&
            is_producer(shadow[k]) && shadow[k].mem_read &&
            shadow[k].rd == bus.id_rs[i*REG_AW +: REG_AW])
          hazard[i] = 1'b1;
      end
    end
  end

  assign stall_c = |hazard;
  assign take    = bus.id_valid && !stall_c && !bus.flush;

  // Forward select per operand; scanning oldest to youngest lets the youngest
  // matching producer overwrite older matches.
  always_comb begin
    sel_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (bus.id_rs_used[i] && bus.id_rs[i*REG_AW +: REG_AW] != '0 &&
            is_producer(shadow[k]) &&
            shadow[k].rd == bus.id_rs[i*REG_AW +: REG_AW])
          sel_d[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
      end
    end
  end

  // Shadow pipeline advance: ID instruction or bubble into EX, rest shift down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the whole shadow array is reset, not only the valid bits; it is a
      // handful of flops and a stale valid would forward from a dead producer.
      for (int k = 0; k <= FWD_DEPTH; k++) shadow[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage read the previous
      // cycle's value, so the shift order inside the loop does not matter.
      shadow[0] <= take ? id_entry : '0;
      for (int k = 1; k <= FWD_DEPTH; k++) shadow[k] <= shadow[k-1];
    end
  end

  // Forward selects travel with the instruction into EX; a bubble forwards nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sel_q <= '0;
    else if (take) sel_q <= sel_d;
    else           sel_q <= '0;
  end

  // Saturating stall-cycle counter for performance monitoring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt_q <= '0;
    else if (stall_c && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign bus.stall       = stall_c;
  assign bus.fwd_sel     = sel_q;
  assign bus.stall_count = cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational ALU forwarding unit.
- Tracks in-flight producers internally in a shadow pipeline (EX, MEM, WB, and deeper stages) and resolves per-operand forward selects one cycle early, in ID. The selects are registered so they reach EX aligned with the consuming instruction.
- Also detects load-use hazards (stall plus bubble insertion) and counts stall cycles for performance monitoring.
- Sits beside the ID/EX pipeline register and drives the ALU operand muxes and the IF/ID stall.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- FWD_DEPTH, 2, number of forwardable producer stages after EX (1 = EX/MEM, 2 = MEM/WB, ...). Minimum 1.
- LOAD_LAT, 1, number of shadow stages, starting at EX, in which load data is not yet available. Range 1..FWD_DEPTH.
- SEL_W, $clog2(FWD_DEPTH+1), width of each forward select.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NUM_SRC*REG_AW  source register addresses; operand i is at bits [i*REG_AW +: REG_AW].
- id_rs_used  in  NUM_SRC  bit i set = operand i is read.
- id_rd  in  REG_AW  destination register.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- flush  in  1  squash the ID instruction (branch/jump resolved).
- stall  out  1  hold PC and IF/ID; insert a bubble into EX (combinational).
- fwd_sel  out  NUM_SRC*SEL_W  registered, for the instruction now in EX. Value 0 = register file; value k = result of stage EX+k.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Shadow entries s[0..FWD_DEPTH]: s[0] = EX, s[1] = MEM, and so on. Each entry holds {valid, rd, reg_write, mem_read}.
- An entry is a producer only if valid & reg_write & rd != 0.
- Every cycle s[k+1] <= s[k].
  - s[0] <= ID instruction if id_valid & !stall & !flush.
  - Otherwise s[0] <= bubble (valid = 0).
- Load-use check, per operand i. hazard_i is true when all of the following hold:
  - id_valid & id_rs_used[i] & !flush;
  - some s[k] with k < LOAD_LAT is a producer with mem_read = 1 and rd == id_rs[i].
- stall = OR of all hazard_i. It is forced to 0 when flush = 1 (flush has priority).
- Forward select, per operand i, computed in ID and captured at the clock edge:
  - Candidates are current s[0..FWD_DEPTH-1], which become stages 1..FWD_DEPTH next cycle.
  - Pick the youngest (lowest k) producer with rd == id_rs[i]; next fwd_sel[i] = k+1.
  - No match, operand unused, or id_rs[i] == 0 -> 0.
  - A load match in a stage >= LOAD_LAT is legal (data is ready).
- When s[0] receives a bubble (stall, flush or !id_valid), all fwd_sel fields <= 0.
- Youngest-wins rule: if the same rd is in flight in several stages, the smallest distance wins. Priority is per operand and independent across operands; both operands may match the same stage.
- Register-file write-through for stages beyond FWD_DEPTH is the register file's responsibility; this block never selects them.
- stall_count increments on every cycle with stall = 1 and saturates at all-ones. Never wraps.
- Reset (async, any time, including mid-stall): all shadow valids = 0, fwd_sel = 0, stall_count = 0. Hence stall = 0 immediately.
- Latency:
  - stall: 0 cycles (combinational from ID inputs and shadow state).
  - fwd_sel: 1 cycle (registered at the ID->EX transfer).
- Simultaneous events:
  - flush & hazard: no stall, bubble inserted.
  - stall persists while the load stays inside the LOAD_LAT window. With LOAD_LAT = 1 that is exactly 1 cycle; the shadow keeps advancing during the stall.

Test Plan:
- Back-to-back ALU dependency: issue "rd=5 write", then "rs1=5". In the second instruction's EX cycle, fwd_sel[0] = 1 and fwd_sel[1] = 0; stall never asserts.
- Distance-2 dependency and youngest-wins:
  - "rd=7", "rd=7", "rs2=7" -> fwd_sel[1] = 1.
  - "rd=7", nop, "rs2=7" -> fwd_sel[1] = 2.
- Load-use: load "rd=3", then "rs1=3":
  - stall = 1 for exactly 1 cycle and a bubble enters EX;
  - then the consumer reaches EX with fwd_sel[0] = 2;
  - stall_count = 1.
- x0 and unused operands:
  - load "rd=0" followed by "rs1=0" -> no stall, fwd_sel = 0.
  - id_rs_used = 2'b00 with matching addresses -> fwd_sel = 0, no stall.
- Flush priority: load "rd=4", then an "rs1=4" instruction with flush = 1 -> stall = 0, EX receives a bubble, fwd_sel = 0, stall_count unchanged.
- Reset and saturation:
  - Assert rst mid-stall -> stall drops to 0 asynchronously; all outputs 0 and no forwarding from pre-reset producers.
  - With CNT_W = 4, hold a load hazard for 20 stall cycles -> stall_count = 15.
